hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl_perf_cnt.sv | 24 ++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller slice.
// Contents:
//   REG_ADDR_W  - architectural register address width (x0..x31)
//   hz_state_t  - hazard FSM state (RUN, STALL)
package riscv_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side; drives ID/EX operand info and branch resolve,
//         receives the PC/IF-ID enables, bubble and flush controls.
// slave : hazard controller side (reverse directions).
interface hazard_ctrl_if;
  import riscv_pipe_pkg::*;

  logic [REG_ADDR_W-1:0] idRs1;
  logic [REG_ADDR_W-1:0] idRs2;
  logic                  idUseRs1;
  logic                  idUseRs2;
  logic [REG_ADDR_W-1:0] exWrReg;
  logic                  exMemRead;
  logic                  exRegWrite;
  logic                  memBranchTaken;

  logic                  pcWrite;
  logic                  ifidWrite;
  logic                  idexBubble;
  logic                  ifidFlush;
  logic                  idexFlush;
  logic                  exmemFlush;

  modport master (
    output idRs1, idRs2, idUseRs1, idUseRs2,
    output exWrReg, exMemRead, exRegWrite, memBranchTaken,
    input  pcWrite, ifidWrite, idexBubble, ifidFlush, idexFlush, exmemFlush
  );

  modport slave (
    input  idRs1, idRs2, idUseRs1, idUseRs2,
    input  exWrReg, exMemRead, exRegWrite, memBranchTaken,
    output pcWrite, ifidWrite, idexBubble, ifidFlush, idexFlush, exmemFlush
  );

endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: saturating event counter.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high clear
//   inc  - count this cycle
//   cnt  - current count, sticks at all-ones
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and branch flush control for a 5-stage pipe.
// Parameters:
//   LOAD_BUBBLES - bubbles per load-use hazard (1..3)
//   CNT_W        - performance counter width
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   hz (slave)   - ID/EX operand info, branch resolve, stall/flush controls
//   stallCnt     - bubble-cycle count     (only with HAZARD_PERF_EN)
//   flushCnt     - flush-cycle count      (only with HAZARD_PERF_EN)
// Build option: define HAZARD_PERF_EN to add the saturating counters.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
`endif
);

  if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 3) begin : g_bad_bubbles
    $error("hazard_ctrl: LOAD_BUBBLES must be 1..3");
  end

  localparam logic [1:0] BUB_INIT = 2'(LOAD_BUBBLES - 1);

  hz_state_t  state, state_n;
  logic [1:0] bubLeft, bubLeft_n;
  logic       hazard;
  logic       rs1_hit, rs2_hit;

  // x0 never carries a value produced by the load, so it is never a hazard.
  assign rs1_hit = hz.idUseRs1 && (hz.exWrReg == hz.idRs1);
  assign rs2_hit = hz.idUseRs2 && (hz.exWrReg == hz.idRs2);
  assign hazard  = hz.exMemRead && hz.exRegWrite && (hz.exWrReg != '0) &&
                   (rs1_hit || rs2_hit);

  // Outputs: reset forces the idle values; a taken branch overrides any stall.
  always_comb begin
    hz.pcWrite    = 1'b1;
    hz.ifidWrite  = 1'b1;
    hz.idexBubble = 1'b0;
    hz.ifidFlush  = 1'b0;
    hz.idexFlush  = 1'b0;
    hz.exmemFlush = 1'b0;
    if (!rst) begin
      if (hz.memBranchTaken) begin
        hz.ifidFlush  = 1'b1;
        hz.idexFlush  = 1'b1;
        hz.exmemFlush = 1'b1;
      end else if ((state == STALL) || hazard) begin
        hz.pcWrite    = 1'b0;
        hz.ifidWrite  = 1'b0;
        hz.idexBubble = 1'b1;
      end
    end
  end

  // bubLeft counts the bubbles still owed after the current one; leaving
  // STALL on the edge it runs out gives exactly LOAD_BUBBLES bubbles total.
  always_comb begin
    state_n   = state;
    bubLeft_n = bubLeft;
    if (hz.memBranchTaken) begin
      state_n   = RUN;
      bubLeft_n = '0;
    end else if (state == STALL) begin
      if (bubLeft <= 2'd1) begin
        state_n   = RUN;
        bubLeft_n = '0;
      end else begin
        bubLeft_n = bubLeft - 2'd1;
      end
    end else if (hazard && (LOAD_BUBBLES > 1)) begin
      state_n   = STALL;
      bubLeft_n = BUB_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      bubLeft <= '0;
    end else begin
      state   <= state_n;
      bubLeft <= bubLeft_n;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hz.idexBubble),
    .cnt (stallCnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hz.ifidFlush),
    .cnt (flushCnt)
  );
`endif

endmodule
